multi_digit_bcd_counter: RTL and testbench
==========================================

MULTI_DIGIT_BCD_COUNTER -- requirements
Module: multi_digit_bcd_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of cascaded BCD digits, legal range 1..8.
REQ-002 SHALL have parameter WRAP, default 1: 1 = roll over at the count limits, 0 = saturate at the count limits.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up_down  input  1  1 = count up, 0 = count down.
REQ-007 SHALL have port load  input  1  synchronous parallel-load strobe.
REQ-008 SHALL have port load_val  input  4*DIGITS  BCD load value; digit i at bits [4i+3:4i], digit 0 least significant.
REQ-009 SHALL have port count  output  4*DIGITS  registered BCD count, same digit packing as load_val.
REQ-010 SHALL have port tc  output  1  combinational terminal count.
REQ-011 SHALL have port ovf  output  1  registered one-cycle pulse on a limit crossing.
REQ-012 SHALL have port load_err  output  1  registered one-cycle pulse when a load is rejected.

Function
REQ-013 Per-edge priority SHALL be: reset, then load, then en; with none active, count holds.
REQ-014 Load SHALL be accepted only if every digit of load_val is 0..9; count = load_val on the next edge, regardless of en.
REQ-015 A load with any digit 10..15 SHALL be rejected: count unchanged, en ignored that cycle, load_err = 1 for exactly the following cycle.
REQ-016 With en=1 and up_down=1, digit 0 SHALL increment; a digit at 9 goes to 0 and generates a carry into the next digit; a carry into a digit increments it by the same rule; all digit updates occur in the same edge (single-cycle latency).
REQ-017 With en=1 and up_down=0, digit 0 SHALL decrement; a digit at 0 goes to 9 and generates a borrow into the next digit; a borrow into a digit decrements it by the same rule.
REQ-018 Count up at all-nines SHALL give count = all zeros if WRAP=1, or hold all nines if WRAP=0; ovf = 1 on the next cycle in both cases.
REQ-019 Count down at all zeros SHALL give count = all nines if WRAP=1, or hold all zeros if WRAP=0; ovf = 1 on the next cycle in both cases.
REQ-020 tc SHALL equal en & ~load & (up_down ? count==all nines : count==all zeros).
REQ-021 ovf SHALL be 0 in every cycle that does not follow a limit crossing; a load never produces ovf.
REQ-022 Each digit of count SHALL remain 0..9 at all times after reset; no non-BCD code is ever produced.
REQ-023 Changing up_down between cycles SHALL take effect on the next enabled edge, with no extra latency and no lost count.

Reset
REQ-024 On a reset edge, count SHALL become all zeros and ovf and load_err SHALL become 0, overriding load and en.
REQ-025 A reset asserted mid-count or in the cycle of a rejected load SHALL suppress any pending ovf or load_err pulse on the next cycle.
REQ-026 After reset, tc SHALL follow REQ-020 using the reset count value.

Verification
REQ-027 DIGITS=2, WRAP=1: reset; en=1, up_down=1 for 100 cycles -> count steps 00,01..09,10..99, then 00; ovf = 1 only in the cycle after 99->00.
REQ-028 DIGITS=2, WRAP=1: load 0x00, then down one step -> count 0x99 and ovf pulses; tc = 1 in the load-following cycle (en=1, up_down=0).
REQ-029 DIGITS=2, WRAP=0: load 0x98, count up 3 cycles -> count 99,99,99; ovf pulses on the second and third cycles; tc stays 1 while at 99.
REQ-030 DIGITS=2: count at 0x37; load 0x3A with en=1 -> count stays 0x37 and load_err pulses once; then load 0x59 with en=1 -> count 0x59 and no increment that cycle.
REQ-031 DIGITS=4: load 0x0999, count up once -> count 0x1000 (triple carry in one edge); then count down once -> count 0x0999.
REQ-032 DIGITS=2: reset and load asserted together with load_val 0x55 -> count 0x00; en=1 at 0x99 with reset in the same cycle -> count 0x00 and no ovf.

Source files
------------

// File: rtl/multi_digit_bcd_counter.sv
// Cascaded BCD up/down counter with parallel load, wrap/saturate limits,
// terminal-count, overflow and rejected-load flags.
module multi_digit_bcd_counter #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned WRAP   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up_down,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tc,
   output logic                  ovf,
   output logic                  load_err
);

   localparam int unsigned Width = 4 * DIGITS;
   localparam logic [Width-1:0] AllNines = {DIGITS{4'h9}};

   logic [Width-1:0] count_q, count_d, stepped;
   logic             ovf_q, ovf_d, load_err_q, load_err_d;
   logic             load_ok, at_limit, ripple;

   always_comb begin
      load_ok = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
      end
   end

   assign at_limit = up_down ? (count_q == AllNines) : (count_q == '0);

   // Carry/borrow ripples from digit 0 upward; stops at the first digit that
   // does not wrap, so every digit settles in the same edge.
   always_comb begin
      stepped = count_q;
      ripple  = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (ripple) begin
            if (up_down) begin
               if (count_q[4*i +: 4] == 4'd9) begin
                  stepped[4*i +: 4] = 4'd0;
               end else begin
                  stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                  ripple            = 1'b0;
               end
            end else begin
               if (count_q[4*i +: 4] == 4'd0) begin
                  stepped[4*i +: 4] = 4'd9;
               end else begin
                  stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                  ripple            = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      count_d    = count_q;
      ovf_d      = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if (load_ok) count_d    = load_val;
         else         load_err_d = 1'b1;
      end else if (en) begin
         ovf_d = at_limit;
         // Saturating mode freezes at the limit instead of taking the wrapped value.
         if (!at_limit || (WRAP != 0)) count_d = stepped;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= '0;
         ovf_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         load_err_q <= load_err_d;
      end
   end

   assign count    = count_q;
   assign ovf      = ovf_q;
   assign load_err = load_err_q;
   assign tc       = en & ~load & at_limit;

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Bench for multi_digit_bcd_counter: three configurations checked every cycle
// against an integer-valued model, plus directed literal scenarios.
module tb_multi_digit_bcd_counter;

   logic        clk;
   logic        reset, en, up_down, load;
   logic [7:0]  lv2;
   logic [15:0] lv4;
   logic [7:0]  cnt0, cnt1;
   logic [15:0] cnt2;
   logic [2:0]  tc_v, ovf_v, err_v;

   int checks = 0;
   int errors = 0;

   multi_digit_bcd_counter #(.DIGITS(2), .WRAP(1)) u_d2w1 (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
      .load_val(lv2), .count(cnt0), .tc(tc_v[0]), .ovf(ovf_v[0]), .load_err(err_v[0])
   );
   multi_digit_bcd_counter #(.DIGITS(2), .WRAP(0)) u_d2w0 (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
      .load_val(lv2), .count(cnt1), .tc(tc_v[1]), .ovf(ovf_v[1]), .load_err(err_v[1])
   );
   multi_digit_bcd_counter #(.DIGITS(4), .WRAP(1)) u_d4w1 (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
      .load_val(lv4), .count(cnt2), .tc(tc_v[2]), .ovf(ovf_v[2]), .load_err(err_v[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int max_of(input int d);
      int m = 1;
      for (int i = 0; i < d; i++) m = m * 10;
      return m - 1;
   endfunction

   function automatic bit bcd_ok(input logic [31:0] v, input int d);
      for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int bcd2int(input logic [31:0] v, input int d);
      int r = 0;
      for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [31:0] int2bcd(input int v, input int d);
      logic [31:0] r = '0;
      int x = v;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Model: counts held as plain decimal integers.
   int dig  [3] = '{2, 2, 4};
   bit wrap [3] = '{1'b1, 1'b0, 1'b1};
   int m_val[3];
   bit m_ovf[3];
   bit m_err[3];
   bit armed = 1'b0;

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         logic [31:0] lv;
         int mx;
         lv = (k == 2) ? 32'(lv4) : 32'(lv2);
         mx = max_of(dig[k]);
         m_ovf[k] = 1'b0;
         m_err[k] = 1'b0;
         if (reset) begin
            m_val[k] = 0;
         end else if (load) begin
            if (bcd_ok(lv, dig[k])) m_val[k] = bcd2int(lv, dig[k]);
            else                    m_err[k] = 1'b1;
         end else if (en) begin
            if (up_down) begin
               if (m_val[k] == mx) begin
                  m_ovf[k] = 1'b1;
                  m_val[k] = wrap[k] ? 0 : mx;
               end else m_val[k] = m_val[k] + 1;
            end else begin
               if (m_val[k] == 0) begin
                  m_ovf[k] = 1'b1;
                  m_val[k] = wrap[k] ? mx : 0;
               end else m_val[k] = m_val[k] - 1;
            end
         end
      end
      if (reset) armed = 1'b1;
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int k = 0; k < 3; k++) begin
            logic [31:0] act;
            bit exp_tc;
            act = (k == 0) ? 32'(cnt0) : (k == 1) ? 32'(cnt1) : 32'(cnt2);
            exp_tc = en && !load &&
                     (up_down ? (m_val[k] == max_of(dig[k])) : (m_val[k] == 0));
            chk($sformatf("u%0d.count", k), act, int2bcd(m_val[k], dig[k]));
            chk($sformatf("u%0d.ovf", k), 32'(ovf_v[k]), 32'(m_ovf[k]));
            chk($sformatf("u%0d.load_err", k), 32'(err_v[k]), 32'(m_err[k]));
            chk($sformatf("u%0d.tc", k), 32'(tc_v[k]), 32'(exp_tc));
         end
      end
   end

   task automatic drive(input logic r, input logic e, input logic ud, input logic ld,
                        input logic [7:0] v2, input logic [15:0] v4);
      reset = r; en = e; up_down = ud; load = ld; lv2 = v2; lv4 = v4;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_lv(input int d);
      logic [31:0] r = '0;
      int sel = $urandom_range(0, 7);
      for (int i = 0; i < d; i++) begin
         case (sel)
            0:       r[4*i +: 4] = 4'($urandom_range(0, 15));
            1:       r[4*i +: 4] = 4'd9;
            2:       r[4*i +: 4] = 4'd0;
            default: r[4*i +: 4] = 4'($urandom_range(0, 9));
         endcase
      end
      return r;
   endfunction

   initial begin
      drive(1, 0, 1, 0, 8'h00, 16'h0000);
      chk("reset.count", 32'(cnt0), 32'h00);
      chk("reset.ovf", 32'(ovf_v[0]), 32'h0);
      chk("reset.load_err", 32'(err_v[0]), 32'h0);

      // Full 2-digit up sweep with wrap.
      for (int i = 1; i <= 100; i++) begin
         drive(0, 1, 1, 0, 8'h00, 16'h0000);
         chk("sweep.count", 32'(cnt0), 32'(((i % 100) / 10) * 16 + (i % 10)));
         chk("sweep.ovf", 32'(ovf_v[0]), 32'(i == 100));
      end

      // Down from 00 wraps to 99.
      drive(0, 0, 0, 1, 8'h00, 16'h0000);
      en = 1'b1; up_down = 1'b0; load = 1'b0;
      #1 chk("down.tc", 32'(tc_v[0]), 32'h1);
      drive(0, 1, 0, 0, 8'h00, 16'h0000);
      chk("down.count", 32'(cnt0), 32'h99);
      chk("down.ovf", 32'(ovf_v[0]), 32'h1);

      // Saturating instance held at 99.
      drive(0, 0, 1, 1, 8'h98, 16'h0098);
      for (int j = 0; j < 3; j++) begin
         drive(0, 1, 1, 0, 8'h00, 16'h0000);
         chk("sat.count", 32'(cnt1), 32'h99);
         chk("sat.ovf", 32'(ovf_v[1]), 32'(j > 0));
         #1 chk("sat.tc", 32'(tc_v[1]), 32'h1);
      end

      // Rejected load then accepted load, both with en high.
      drive(0, 0, 1, 1, 8'h37, 16'h0037);
      drive(0, 1, 1, 1, 8'h3A, 16'h003A);
      chk("rej.count", 32'(cnt0), 32'h37);
      chk("rej.load_err", 32'(err_v[0]), 32'h1);
      drive(0, 1, 1, 1, 8'h59, 16'h0059);
      chk("acc.count", 32'(cnt0), 32'h59);
      chk("acc.load_err", 32'(err_v[0]), 32'h0);

      // Multi-digit carry and borrow in a single edge.
      drive(0, 0, 1, 1, 8'h00, 16'h0999);
      drive(0, 1, 1, 0, 8'h00, 16'h0000);
      chk("carry.count", 32'(cnt2), 32'h1000);
      drive(0, 1, 0, 0, 8'h00, 16'h0000);
      chk("borrow.count", 32'(cnt2), 32'h0999);

      // Reset overrides load and a pending limit crossing.
      drive(1, 0, 1, 1, 8'h55, 16'h0055);
      chk("rstld.count", 32'(cnt0), 32'h00);
      drive(0, 0, 1, 1, 8'h99, 16'h0099);
      drive(1, 1, 1, 0, 8'h00, 16'h0000);
      chk("rsten.count", 32'(cnt0), 32'h00);
      chk("rsten.ovf", 32'(ovf_v[0]), 32'h0);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] v2, v4;
         v2 = rand_lv(2);
         v4 = rand_lv(4);
         drive(logic'($urandom_range(0, 63) == 0), logic'($urandom_range(0, 3) != 0),
               logic'($urandom_range(0, 1)), logic'($urandom_range(0, 7) == 0),
               v2[7:0], v4[15:0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
